// File: rtl/det_pkg.sv
// Shared keypad/detonator definitions: key and button counts, button bit
// positions, the digit type and the key-path FSM state encoding.
package det_pkg;

  localparam int KEY_NUM = 10;
  localparam int BTN_NUM = 5;

  localparam int BTN_SETUP  = 0;
  localparam int BTN_READY  = 1;
  localparam int BTN_SURE   = 2;
  localparam int BTN_FIRE   = 3;
  localparam int BTN_WAIT_T = 4;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    KS_IDLE     = 2'd0,
    KS_DB_PRESS = 2'd1,
    KS_HELD     = 2'd2,
    KS_DB_REL   = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce_cell.sv
// Single-bit conditioner: 2-flop synchroniser, saturating stability counter
// and a one-cycle pulse on the rising edge of the debounced level.
module key_debounce_cell #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             pulse_reg;
  logic [CNT_W-1:0] cnt_reg;

  // The counter tracks how long the synchronised input has disagreed with the
  // accepted level; any agreement restarts it, so only unbroken runs count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DB_LIM) begin
        level_reg <= sync2_reg;
        pulse_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/keypad_input_conditioner.sv
// Keypad/button front end: debounced, chord-checked digit strobes from the
// 10 one-hot keys plus single-cycle press pulses for the 5 command buttons.
module keypad_input_conditioner
  import det_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_raw,
  input  logic [BTN_NUM-1:0] btn_raw,
  output logic [3:0]         digit,
  output logic               digit_vld,
  output logic               key_err,
  output logic               key_busy,
  output logic [BTN_NUM-1:0] btn_pulse
);

  localparam logic [1:0] ST_IDLE     = KS_IDLE;
  localparam logic [1:0] ST_DB_PRESS = KS_DB_PRESS;
  localparam logic [1:0] ST_HELD     = KS_HELD;
  localparam logic [1:0] ST_DB_REL   = KS_DB_REL;

  localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  generate
    if (DB_CYCLES < 1 || DB_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
      $error("keypad_input_conditioner: DB_CYCLES does not fit in CNT_W bits");
    end
  endgenerate

  logic [KEY_NUM-1:0] sync1_reg;
  logic [KEY_NUM-1:0] ks_reg;
  logic [KEY_NUM-1:0] cand_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [1:0]         state_reg;
  digit_t             digit_reg;
  logic               digit_vld_reg;
  logic               key_err_reg;

  digit_t             cand_enc;
  logic [3:0]         cand_ones;
  logic               cand_one_hot;

  // Population count and encoder over the whole candidate vector; a chord is
  // anything other than exactly one set bit.
  always_comb begin
    cand_enc  = '0;
    cand_ones = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (cand_reg[i]) begin
        cand_enc  = digit_t'(i);
        cand_ones = cand_ones + 4'd1;
      end
    end
    cand_one_hot = (cand_ones == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg     <= '0;
      ks_reg        <= '0;
      cand_reg      <= '0;
      cnt_reg       <= '0;
      state_reg     <= ST_IDLE;
      digit_reg     <= '0;
      digit_vld_reg <= 1'b0;
      key_err_reg   <= 1'b0;
    end else begin
      sync1_reg     <= key_raw;
      ks_reg        <= sync1_reg;
      digit_vld_reg <= 1'b0;
      key_err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (ks_reg != '0) begin
            cand_reg  <= ks_reg;
            cnt_reg   <= CNT_W'(1);
            state_reg <= ST_DB_PRESS;
          end
        end
        ST_DB_PRESS: begin
          // A changing key pattern restarts the count on the new pattern.
          if (ks_reg != cand_reg) begin
            if (ks_reg == '0) begin
              state_reg <= ST_IDLE;
            end else begin
              cand_reg <= ks_reg;
              cnt_reg  <= CNT_W'(1);
            end
          end else if (cnt_reg == DB_LIM) begin
            if (cand_one_hot) begin
              digit_vld_reg <= 1'b1;
              digit_reg     <= cand_enc;
            end else begin
              key_err_reg <= 1'b1;
            end
            state_reg <= ST_HELD;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (ks_reg == '0) begin
            cnt_reg   <= CNT_W'(1);
            state_reg <= ST_DB_REL;
          end
        end
        ST_DB_REL: begin
          // Short release glitches fall back to HELD, never to a new press.
          if (ks_reg != '0) begin
            state_reg <= ST_HELD;
          end else if (cnt_reg == DB_LIM) begin
            state_reg <= ST_IDLE;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign digit     = digit_reg;
  assign digit_vld = digit_vld_reg;
  assign key_err   = key_err_reg;
  assign key_busy  = (state_reg != ST_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < BTN_NUM; gi++) begin : g_btn
      key_debounce_cell #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_cell (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw[gi]),
        .pulse (btn_pulse[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_keypad_input_conditioner.sv
// Directed bench for keypad_input_conditioner at DB_CYCLES=4: latency,
// bounce, chord, release-glitch, reset and button-pulse behaviour.
module tb_keypad_input_conditioner;
  import det_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] key_raw = '0;
  logic [4:0] btn_raw = '0;
  logic [3:0] digit;
  logic       digit_vld;
  logic       key_err;
  logic       key_busy;
  logic [4:0] btn_pulse;

  int checks = 0;
  int passed = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int btn_cnt [5] = '{0, 0, 0, 0, 0};
  int v0;
  int e0;

  keypad_input_conditioner #(.DB_CYCLES(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .btn_raw   (btn_raw),
    .digit     (digit),
    .digit_vld (digit_vld),
    .key_err   (key_err),
    .key_busy  (key_busy),
    .btn_pulse (btn_pulse)
  );

  always #5 clk = ~clk;

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (digit_vld) vld_cnt <= vld_cnt + 1;
    if (key_err) err_cnt <= err_cnt + 1;
    for (int b = 0; b < 5; b++) begin
      if (btn_pulse[b]) btn_cnt[b] <= btn_cnt[b] + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // 1: reset with a key already down, then first strobe at cycle 7
    rst = 1'b0;
    key_raw = 10'h004;
    tick(3);
    check("rst_vld", 32'(digit_vld), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_err", 32'(key_err), 32'd0);
    check("rst_busy", 32'(key_busy), 32'd0);
    check("rst_btn", 32'(btn_pulse), 32'd0);
    rst = 1'b1;
    tick(6);
    check("t1_vld_early", 32'(digit_vld), 32'd0);
    tick(1);
    check("t1_vld", 32'(digit_vld), 32'd1);
    check("t1_digit", 32'(digit), 32'd2);
    tick(1);
    check("t1_vld_once", 32'(digit_vld), 32'd0);
    key_raw = '0;
    tick(10);
    check("t1_idle", 32'(key_busy), 32'd0);

    // 2: clean press of digit 5, release timing of key_busy
    v0 = vld_cnt;
    key_raw = 10'h020;
    tick(7);
    check("t2_vld", 32'(digit_vld), 32'd1);
    check("t2_digit", 32'(digit), 32'd5);
    tick(13);
    key_raw = '0;
    tick(6);
    check("t2_busy_held", 32'(key_busy), 32'd1);
    tick(1);
    check("t2_busy_fall", 32'(key_busy), 32'd0);
    check("t2_digit_hold", 32'(digit), 32'd5);
    check("t2_one_strobe", 32'(vld_cnt - v0), 32'd1);

    // 3: bouncing digit 8, then stable
    tick(5);
    v0 = vld_cnt;
    for (int i = 0; i < 12; i++) begin
      key_raw = (((i / 2) % 2) == 0) ? 10'h100 : 10'h000;
      tick(1);
    end
    check("t3_no_bounce_vld", 32'(vld_cnt - v0), 32'd0);
    key_raw = 10'h100;
    tick(6);
    check("t3_vld_early", 32'(digit_vld), 32'd0);
    tick(1);
    check("t3_vld", 32'(digit_vld), 32'd1);
    check("t3_digit", 32'(digit), 32'd8);
    key_raw = '0;
    tick(10);

    // 4: chord 1+2 is flagged, then a lone digit 1 is accepted
    v0 = vld_cnt;
    e0 = err_cnt;
    key_raw = 10'h006;
    tick(6);
    check("t4_err_early", 32'(key_err), 32'd0);
    tick(1);
    check("t4_err", 32'(key_err), 32'd1);
    check("t4_no_vld", 32'(digit_vld), 32'd0);
    tick(3);
    check("t4_err_once", 32'(err_cnt - e0), 32'd1);
    check("t4_vld_none", 32'(vld_cnt - v0), 32'd0);
    key_raw = '0;
    tick(10);
    key_raw = 10'h002;
    tick(7);
    check("t4_vld", 32'(digit_vld), 32'd1);
    check("t4_digit", 32'(digit), 32'd1);
    key_raw = '0;
    tick(10);

    // 5: sure+fire together, then a short ready glitch
    btn_raw[BTN_SURE] = 1'b1;
    btn_raw[BTN_FIRE] = 1'b1;
    tick(6);
    check("t5_btn_early", 32'(btn_pulse), 32'd0);
    tick(1);
    check("t5_btn_pulse", 32'(btn_pulse), 32'b01100);
    tick(1);
    check("t5_btn_single", 32'(btn_pulse), 32'd0);
    tick(22);
    btn_raw = '0;
    tick(10);
    check("t5_sure_cnt", 32'(btn_cnt[BTN_SURE]), 32'd1);
    check("t5_fire_cnt", 32'(btn_cnt[BTN_FIRE]), 32'd1);
    btn_raw[BTN_READY] = 1'b1;
    tick(3);
    btn_raw = '0;
    tick(10);
    check("t5_ready_glitch", 32'(btn_cnt[BTN_READY]), 32'd0);
    check("t5_setup_quiet", 32'(btn_cnt[BTN_SETUP] + btn_cnt[BTN_WAIT_T]), 32'd0);

    // 6: release glitch on digit 0 does not re-trigger
    v0 = vld_cnt;
    key_raw = 10'h001;
    tick(7);
    check("t6_vld", 32'(digit_vld), 32'd1);
    check("t6_digit", 32'(digit), 32'd0);
    tick(5);
    key_raw = '0;
    tick(3);
    key_raw = 10'h001;
    tick(15);
    check("t6_one_strobe", 32'(vld_cnt - v0), 32'd1);
    check("t6_busy", 32'(key_busy), 32'd1);
    key_raw = '0;
    tick(10);
    check("t6_idle", 32'(key_busy), 32'd0);

    // 7: reset while digit 9 is held, then re-debounced after reset
    key_raw = 10'h200;
    tick(7);
    check("t7_digit", 32'(digit), 32'd9);
    tick(3);
    rst = 1'b0;
    tick(2);
    check("t7_rst_digit", 32'(digit), 32'd0);
    check("t7_rst_busy", 32'(key_busy), 32'd0);
    rst = 1'b1;
    tick(6);
    check("t7_vld_early", 32'(digit_vld), 32'd0);
    tick(1);
    check("t7_vld", 32'(digit_vld), 32'd1);
    check("t7_digit_again", 32'(digit), 32'd9);
    key_raw = '0;
    tick(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
